// File: rtl/calendar_pkg.sv
// Shared types, conversion helpers and standard field ranges for the calendar counter chain.
package calendar_pkg;

    // One BCD digit and a tens/units BCD pair ([7:4] tens, [3:0] units).
    typedef logic [3:0] bcd_digit_t;
    typedef logic [7:0] bcd_pair_t;

    // Binary field value; 0..99 fits in 7 bits.
    typedef logic [6:0] bin7_t;

    // Standard field ranges (binary, inclusive).
    localparam int unsigned SEC_MIN_VAL  = 0;
    localparam int unsigned SEC_MAX_VAL  = 59;
    localparam int unsigned MIN_MIN_VAL  = 0;
    localparam int unsigned MIN_MAX_VAL  = 59;
    localparam int unsigned HR24_MIN_VAL = 0;
    localparam int unsigned HR24_MAX_VAL = 23;
    localparam int unsigned HR12_MIN_VAL = 1;
    localparam int unsigned HR12_MAX_VAL = 12;
    localparam int unsigned DAY_MIN_VAL  = 1;
    localparam int unsigned DAY_MAX_VAL  = 31;
    localparam int unsigned MON_MIN_VAL  = 1;
    localparam int unsigned MON_MAX_VAL  = 12;

    // The single action a counter performs in a cycle, highest priority first.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_LOAD,
        ACT_CLAMP,
        ACT_ADJ_UP,
        ACT_ADJ_DOWN,
        ACT_TRIG
    } action_e;

    // Both nibbles hold a decimal digit.
    function automatic logic bcd_is_valid(input bcd_pair_t val);
        return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9);
    endfunction

    // Binary value of a BCD pair; only meaningful for valid pairs.
    function automatic bin7_t bcd_to_bin(input bcd_pair_t val);
        bin7_t tens;
        bin7_t units;
        tens  = {3'b000, val[7:4]};
        units = {3'b000, val[3:0]};
        return (tens * 7'd10) + units;
    endfunction

endpackage

// File: rtl/bcd_range_limits.sv
// Active-mode range limits for a BCD field counter, in BCD digit and binary form.
module bcd_range_limits
    import calendar_pkg::*;
#(
    parameter int unsigned PAR_MIN     = 0,
    parameter int unsigned PAR_MAX     = 23,
    parameter int unsigned PAR_MIN_ALT = 1,
    parameter int unsigned PAR_MAX_ALT = 12
) (
    input  logic       mode_alt,
    input  bcd_digit_t tens,
    output bcd_digit_t min_units,
    output bcd_digit_t max_tens,
    output bcd_digit_t max_units,
    output bin7_t      min_bin,
    output bin7_t      max_bin,
    output bcd_digit_t units_ceiling
);

    // Minimums are single digits, so their tens digit is always zero.
    localparam bin7_t      MIN_PRI_BIN   = bin7_t'(PAR_MIN);
    localparam bin7_t      MAX_PRI_BIN   = bin7_t'(PAR_MAX);
    localparam bcd_digit_t MIN_PRI_UNITS = bcd_digit_t'(PAR_MIN);
    localparam bcd_digit_t MAX_PRI_TENS  = bcd_digit_t'(PAR_MAX / 10);
    localparam bcd_digit_t MAX_PRI_UNITS = bcd_digit_t'(PAR_MAX % 10);

    localparam bin7_t      MIN_ALT_BIN   = bin7_t'(PAR_MIN_ALT);
    localparam bin7_t      MAX_ALT_BIN   = bin7_t'(PAR_MAX_ALT);
    localparam bcd_digit_t MIN_ALT_UNITS = bcd_digit_t'(PAR_MIN_ALT);
    localparam bcd_digit_t MAX_ALT_TENS  = bcd_digit_t'(PAR_MAX_ALT / 10);
    localparam bcd_digit_t MAX_ALT_UNITS = bcd_digit_t'(PAR_MAX_ALT % 10);

    // Pick the limit set of the currently selected range mode.
    always_comb begin
        min_units = MIN_PRI_UNITS;
        max_tens  = MAX_PRI_TENS;
        max_units = MAX_PRI_UNITS;
        min_bin   = MIN_PRI_BIN;
        max_bin   = MAX_PRI_BIN;
        if (mode_alt) begin
            min_units = MIN_ALT_UNITS;
            max_tens  = MAX_ALT_TENS;
            max_units = MAX_ALT_UNITS;
            min_bin   = MIN_ALT_BIN;
            max_bin   = MAX_ALT_BIN;
        end
    end

    // Largest units digit allowed under the given tens digit: min(9, MAX - 10*tens).
    always_comb begin
        units_ceiling = 4'd9;
        if (tens == max_tens) begin
            units_ceiling = max_units;
        end else if (tens > max_tens) begin
            units_ceiling = '0;
        end
    end

endmodule

// File: rtl/bcd_range_counter.sv
// Two-digit BCD field counter: primary/alternate range, carry chaining, per-digit adjust
// and validated parallel load.
module bcd_range_counter
    import calendar_pkg::*;
#(
    parameter int unsigned PAR_MIN     = 0,
    parameter int unsigned PAR_MAX     = 23,
    parameter int unsigned PAR_MIN_ALT = 1,
    parameter int unsigned PAR_MAX_ALT = 12
) (
    input  logic       I_SYS_CLK,
    input  logic       I_EXT_RST_N,
    input  logic       I_MODE_ALT,
    input  logic       I_LOAD_EN,
    input  logic [7:0] I_LOAD_VAL,
    input  logic       I_ADJ_UP,
    input  logic       I_ADJ_DOWN,
    input  logic [1:0] I_ADJ_SEL,
    input  logic       I_TRIG_F,
    output logic       O_TRIG_F,
    output logic       O_LOAD_ERR,
    output logic [3:0] O_COUNTA,
    output logic [3:0] O_COUNTB
);

    bcd_digit_t count_a_q, count_a_d;
    bcd_digit_t count_b_q, count_b_d;
    logic       trig_q, trig_d;
    logic       load_err_q, load_err_d;

    bcd_digit_t min_units;
    bcd_digit_t max_tens;
    bcd_digit_t max_units;
    bin7_t      min_bin;
    bin7_t      max_bin;
    bcd_digit_t units_ceiling;

    bin7_t      v_bin;
    bin7_t      load_bin;
    logic       load_ok;
    logic       sel_units;
    logic       sel_tens;
    action_e    action;

    bcd_digit_t tens_adj_b;
    bcd_digit_t tens_adj_a;
    bin7_t      tens_adj_bin;

    bcd_range_limits #(
        .PAR_MIN     (PAR_MIN),
        .PAR_MAX     (PAR_MAX),
        .PAR_MIN_ALT (PAR_MIN_ALT),
        .PAR_MAX_ALT (PAR_MAX_ALT)
    ) u_limits (
        .mode_alt      (I_MODE_ALT),
        .tens          (count_b_q),
        .min_units     (min_units),
        .max_tens      (max_tens),
        .max_units     (max_units),
        .min_bin       (min_bin),
        .max_bin       (max_bin),
        .units_ceiling (units_ceiling)
    );

    // Binary views of the current value and the load candidate, plus digit selection.
    always_comb begin
        v_bin     = bcd_to_bin({count_b_q, count_a_q});
        load_bin  = bcd_to_bin(I_LOAD_VAL);
        load_ok   = bcd_is_valid(I_LOAD_VAL) && (load_bin >= min_bin) && (load_bin <= max_bin);
        sel_units = ~I_ADJ_SEL[0];
        sel_tens  = I_ADJ_SEL[0] & ~I_ADJ_SEL[1];
    end

    // Choose the one action for this cycle; lower-priority requests are dropped.
    always_comb begin
        action = ACT_NONE;
        if (I_LOAD_EN) begin
            action = ACT_LOAD;
        end else if ((v_bin > max_bin) || (v_bin < min_bin)) begin
            action = ACT_CLAMP;
        end else if (I_ADJ_UP) begin
            action = ACT_ADJ_UP;
        end else if (I_ADJ_DOWN) begin
            action = ACT_ADJ_DOWN;
        end else if (I_TRIG_F) begin
            action = ACT_TRIG;
        end
    end

    // Tens-adjust candidate; the units digit is pulled back into range in the same cycle.
    always_comb begin
        if (action == ACT_ADJ_UP) begin
            // 10*(B+1) > MAX is the same as B >= MAX/10 in integer digits.
            tens_adj_b = (count_b_q >= max_tens) ? '0 : count_b_q + 4'd1;
        end else begin
            tens_adj_b = (count_b_q == '0) ? max_tens : count_b_q - 4'd1;
        end
        tens_adj_bin = bcd_to_bin({tens_adj_b, count_a_q});
        tens_adj_a   = count_a_q;
        if (tens_adj_bin > max_bin) begin
            tens_adj_a = max_units;
        end else if (tens_adj_bin < min_bin) begin
            tens_adj_a = min_units;
        end
    end

    // Next value and flags for the selected action.
    always_comb begin
        count_a_d  = count_a_q;
        count_b_d  = count_b_q;
        trig_d     = 1'b0;
        load_err_d = 1'b0;
        unique case (action)
            ACT_LOAD: begin
                if (load_ok) begin
                    count_b_d = I_LOAD_VAL[7:4];
                    count_a_d = I_LOAD_VAL[3:0];
                end else begin
                    load_err_d = 1'b1;
                end
            end
            ACT_CLAMP: begin
                if (v_bin > max_bin) begin
                    count_b_d = max_tens;
                    count_a_d = max_units;
                end else begin
                    count_b_d = '0;
                    count_a_d = min_units;
                end
            end
            ACT_ADJ_UP: begin
                if (sel_units) begin
                    // Value is in range here, so V+1 > MAX is V >= MAX.
                    if ((count_a_q == 4'd9) || (v_bin >= max_bin)) begin
                        count_a_d = (count_b_q == '0) ? min_units : '0;
                    end else begin
                        count_a_d = count_a_q + 4'd1;
                    end
                end else if (sel_tens) begin
                    count_b_d = tens_adj_b;
                    count_a_d = tens_adj_a;
                end
            end
            ACT_ADJ_DOWN: begin
                if (sel_units) begin
                    // V-1 < MIN is V <= MIN.
                    if ((count_a_q == '0) || (v_bin <= min_bin)) begin
                        count_a_d = units_ceiling;
                    end else begin
                        count_a_d = count_a_q - 4'd1;
                    end
                end else if (sel_tens) begin
                    count_b_d = tens_adj_b;
                    count_a_d = tens_adj_a;
                end
            end
            ACT_TRIG: begin
                if (v_bin == max_bin) begin
                    count_b_d = '0;
                    count_a_d = min_units;
                    trig_d    = 1'b1;
                end else if (count_a_q == 4'd9) begin
                    count_a_d = '0;
                    count_b_d = count_b_q + 4'd1;
                end else begin
                    count_a_d = count_a_q + 4'd1;
                end
            end
            default: begin
            end
        endcase
    end

    // Value and pulse flags; reset restarts at the active-mode minimum.
    always_ff @(posedge I_SYS_CLK) begin
        if (!I_EXT_RST_N) begin
            count_a_q  <= min_units;
            count_b_q  <= '0;
            trig_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_a_q  <= count_a_d;
            count_b_q  <= count_b_d;
            trig_q     <= trig_d;
            load_err_q <= load_err_d;
        end
    end

    assign O_COUNTA   = count_a_q;
    assign O_COUNTB   = count_b_q;
    assign O_TRIG_F   = trig_q;
    assign O_LOAD_ERR = load_err_q;

endmodule
